// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display driver: glyph patterns
// (active-high, bit order g..a) and helpers for sizing the scan counters.
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // A single-digit display still needs a one-bit index register.
    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    function automatic int presc_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD-to-segment decoder for the currently scanned digit.
// Codes above 9 show a dash so bad data is visible rather than garbled.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [6:0] glyph;

    always_comb begin
        glyph = SEG_DASH;
        case (code)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
        pattern = blank ? {1'b0, SEG_OFF} : {dp, glyph};
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed N-digit seven-segment driver with leading-zero blanking,
// whole-display blink and a frame-complete pulse.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    blink,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = presc_width(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [7:0]            SEG_IDLE = {8{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRM_W-1:0]        frm_cnt_q, frm_cnt_d;
    logic                    phase_on_q, phase_on_d;
    logic                    wrap_q, wrap_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    frame_end;
    logic                    lead_zero;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [3:0]              sel_code;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [7:0]              pattern;

    always_comb begin
        slot_end  = (presc_q == LAST_PRE);
        frame_end = slot_end && (idx_q == LAST_IDX);

        presc_d = slot_end ? '0 : presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        // Blink phase only advances on frame boundaries so on/off spans whole frames.
        frm_cnt_d  = frm_cnt_q;
        phase_on_d = phase_on_q;
        if (!blink) begin
            frm_cnt_d  = '0;
            phase_on_d = 1'b1;
        end else if (frame_end) begin
            if (frm_cnt_q == LAST_FRM) begin
                frm_cnt_d  = '0;
                phase_on_d = !phase_on_q;
            end else begin
                frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
        end

        // frame_done lags the wrap by one so it lines up with digit 0 on the pins.
        wrap_d       = frame_end;
        frame_done_d = wrap_q;

        bcd_d = load ? bcd_in : bcd_q;
        dp_d  = load ? dp_in  : dp_q;
    end

    always_comb begin
        lead_zero  = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero     = lead_zero && (bcd_q[4*i +: 4] == 4'd0) && !dp_q[i];
            blank_mask[i] = lead_zero;
        end

        sel_code  = bcd_q[3:0];
        sel_dp    = dp_q[0];
        sel_blank = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_code     = bcd_q[4*i +: 4];
                sel_dp       = dp_q[i];
                sel_blank    = lz_blank && blank_mask[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    seg_digit_decode u_decode (
        .code    (sel_code),
        .dp      (sel_dp),
        .blank   (sel_blank),
        .pattern (pattern)
    );

    always_comb begin
        seg_d = pattern ^ {8{ACTIVE_LOW}};
        an_d  = ((blink && !phase_on_q) ? '0 : an_onehot) ^ {NUM_DIGITS{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frm_cnt_q    <= '0;
            phase_on_q   <= 1'b1;
            wrap_q       <= 1'b0;
            bcd_q        <= '0;
            dp_q         <= '0;
            seg_q        <= SEG_IDLE;
            an_q         <= AN_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frm_cnt_q    <= frm_cnt_d;
            phase_on_q   <= phase_on_d;
            wrap_q       <= wrap_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: directed scenarios followed by
// randomized traffic, all compared against a cycle-count based display model.
module tb_seg_display_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FRAME = RD * ND;

    logic            clk;
    logic            rst;
    logic [4*ND-1:0] bcd_in;
    logic [ND-1:0]   dp_in;
    logic            load;
    logic            lz_blank;
    logic            blink;
    logic [7:0]      seg;
    logic [ND-1:0]   an;
    logic            frame_done;

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset release, display contents, frames seen while blinking.
    int         e_cnt;
    logic [3:0] m_bcd [ND];
    logic [ND-1:0] m_dp;
    int         bf_cnt;

    seg_display_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .blink      (blink),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic applyStimulus(input logic r, input logic ld, input logic [4*ND-1:0] b,
                                 input logic [ND-1:0] d, input logic lz, input logic bl);
        rst      = r;
        load     = ld;
        bcd_in   = b;
        dp_in    = d;
        lz_blank = lz;
        blink    = bl;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // One clock: predict the pins from pre-edge state, clock, update the model, compare.
    task automatic step(input string tag);
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        logic       exp_fd;
        bit         chk_seg;
        bit         on;
        bit         blanked;
        int         s;
        int         dig;
        int         lead;
        if (rst) begin
            exp_seg = 8'hFF;
            exp_an  = 4'hF;
            exp_fd  = 1'b0;
            chk_seg = 1'b1;
        end else begin
            s    = e_cnt;
            dig  = (s / RD) % ND;
            lead = 0;
            for (int i = 0; i < ND; i++) begin
                if (m_bcd[i] != 4'd0 || m_dp[i]) lead = i;
            end
            blanked = lz_blank && (dig > lead);
            exp_seg = blanked ? 8'h00 : {m_dp[dig], glyph(m_bcd[dig])};
            exp_seg = ~exp_seg;
            on      = !blink || (((bf_cnt / BF) % 2) == 0);
            exp_an  = on ? ~(4'b0001 << dig) : 4'hF;
            chk_seg = on;
            exp_fd  = (s > 0) && ((s % FRAME) == 0);
        end
        @(posedge clk);
        if (rst) begin
            e_cnt  = 0;
            bf_cnt = 0;
            m_dp   = '0;
            for (int i = 0; i < ND; i++) m_bcd[i] = 4'd0;
        end else begin
            if (load) begin
                for (int i = 0; i < ND; i++) m_bcd[i] = bcd_in[4*i +: 4];
                m_dp = dp_in;
            end
            if (!blink) bf_cnt = 0;
            else if ((e_cnt % FRAME) == FRAME - 1) bf_cnt++;
            e_cnt++;
        end
        #1;
        if (chk_seg) checkOutput({tag, ".seg"}, seg, exp_seg);
        checkOutput({tag, ".an"}, {4'h0, an}, {4'h0, exp_an});
        checkOutput({tag, ".frame_done"}, {7'h0, frame_done}, {7'h0, exp_fd});
    endtask

    function automatic logic [4*ND-1:0] rand_bcd();
        logic [4*ND-1:0] v;
        for (int i = 0; i < ND; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        e_cnt  = 0;
        bf_cnt = 0;
        m_dp   = '0;
        for (int i = 0; i < ND; i++) m_bcd[i] = 4'd0;

        // Reset held three cycles, then digit 0 shows "0".
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) step("reset");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step("first_after_reset");

        // Full scan of 1234 with dp on digit 2.
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0);
        step("load_1234");
        applyStimulus(1'b0, 1'b0, 16'h1234, 4'b0100, 1'b0, 1'b0);
        repeat (2 * FRAME) step("scan_1234");

        // Leading-zero blanking.
        applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1, 1'b0);
        step("load_0050");
        applyStimulus(1'b0, 1'b0, 16'h0050, 4'b0000, 1'b1, 1'b0);
        repeat (FRAME) step("lz_0050");
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0);
        step("load_0000");
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
        repeat (FRAME) step("lz_0000");

        // Dash codes, then input changes without load must not reach the display.
        applyStimulus(1'b0, 1'b1, 16'h00AF, 4'b0000, 1'b0, 1'b0);
        step("load_00AF");
        applyStimulus(1'b0, 1'b0, 16'h9876, 4'b1111, 1'b0, 1'b0);
        repeat (FRAME) step("dash_hold");

        // Blink over several phases, then drop it while dark.
        applyStimulus(1'b0, 1'b0, 16'h9876, 4'b0000, 1'b0, 1'b1);
        repeat (5 * FRAME) step("blink");
        for (int i = 0; i < 4 * FRAME && (((bf_cnt / BF) % 2) == 0); i++) step("blink_seek_off");
        step("blink_off");
        applyStimulus(1'b0, 1'b0, 16'h9876, 4'b0000, 1'b0, 1'b0);
        repeat (FRAME) step("blink_drop");

        // Load on the edge where the index advances.
        for (int i = 0; i < RD && ((e_cnt % RD) != RD - 1); i++) step("seek_slot_end");
        applyStimulus(1'b0, 1'b1, 16'h4321, 4'b1000, 1'b0, 1'b0);
        step("load_on_advance");
        applyStimulus(1'b0, 1'b0, 16'h4321, 4'b1000, 1'b0, 1'b0);
        repeat (FRAME) step("after_advance_load");

        // Reset mid-slot at prescaler 2.
        for (int i = 0; i < RD && ((e_cnt % RD) != 2); i++) step("seek_presc2");
        applyStimulus(1'b1, 1'b0, 16'h4321, 4'b1000, 1'b0, 1'b0);
        step("mid_slot_reset");
        applyStimulus(1'b0, 1'b0, 16'h4321, 4'b1000, 1'b0, 1'b0);
        repeat (FRAME + 4) step("restart");

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 5) == 0),
                          rand_bcd(),
                          ND'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0),
                          (n % 97) < 60 ? 1'b1 : 1'b0,
                          (n % 211) > 60 ? 1'b1 : 1'b0);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
